input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 46 ++++
 rtl/input_debounce.sv | 33 +++
 rtl/input_conditioner.sv | 73 +++++++
 tb/tb_input_conditioner.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: game ids, joystick bit map, control modes, coin states and the game mapping.
package input_conditioner_pkg;
  localparam logic [7:0] MOD_DEFENDER = 8'd0;
  localparam logic [7:0] MOD_COLONY7  = 8'd1;
  localparam logic [7:0] MOD_MAYDAY   = 8'd2;
  localparam logic [7:0] MOD_JIN      = 8'd3;
  localparam int B_R       = 0;
  localparam int B_L       = 1;
  localparam int B_D       = 2;
  localparam int B_U       = 3;
  localparam int B_FA      = 4;
  localparam int B_FB      = 5;
  localparam int B_FC      = 6;
  localparam int B_FD      = 7;
  localparam int B_FE      = 8;
  localparam int B_START1  = 9;
  localparam int B_START2  = 10;
  localparam int B_COIN    = 11;
  localparam int B_ADVANCE = 12;
  localparam int B_AUTOUP  = 13;
  localparam int B_HSRESET = 14;
  localparam int B_PAUSE   = 15;
  localparam logic [1:0] CM_MODE1   = 2'b00;
  localparam logic [1:0] CM_MODE2   = 2'b01;
  localparam logic [1:0] CM_CABINET = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_GAP} coin_state_t;
  // Returns {in2, in1} before the DIP OR; ctrl_mode 11 falls through to Mode 1.
  function automatic logic [15:0] map_game(input logic [7:0] m, input logic [1:0] cm,
                                           input logic ds, input logic [15:0] b);
    logic x;
    logic y;
    x = cm == CM_CABINET ? b[B_FE] : cm == CM_MODE2 ? (ds ? b[B_R] : b[B_L]) : b[B_L] | b[B_R];
    y = cm == CM_CABINET ? b[B_FB] : cm == CM_MODE2 ? (ds ? b[B_L] : b[B_R]) : b[B_FB];
    case (m)
      MOD_DEFENDER: map_game = {7'b0, b[B_U], b[B_D], x, b[B_START1], b[B_START2],
                                b[B_FD], b[B_FC], y, b[B_FA]};
      MOD_COLONY7:  map_game = {7'b0, b[B_FC], b[B_FB], b[B_FA], b[B_START1], b[B_START2],
                                b[B_U], b[B_L], b[B_R], b[B_D]};
      MOD_MAYDAY:   map_game = {7'b0, b[B_U], b[B_D], 1'b0, b[B_START1], b[B_START2],
                                b[B_FB], b[B_FC], b[B_R], b[B_FA]};
      MOD_JIN:      map_game = {8'b0, b[B_FB], b[B_FA], b[B_START1], b[B_START2],
                                b[B_R], b[B_L], b[B_D], b[B_U]};
      default:      map_game = 16'h0;
    endcase
  endfunction
endpackage

// File: rtl/input_debounce.sv
// input_debounce: 2-flop synchroniser followed by a consecutive-cycle debouncer for one bit.
module input_debounce #(
  parameter int DEB_CYCLES = 24000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_deb,
  output logic o_next
);
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_deb;
  logic          w_diff;
  logic          w_hit;
  assign w_diff = r_sync[1] ^ r_deb;
  assign w_hit  = w_diff && r_cnt >= CW'(DEB_CYCLES - 1);
  // o_next lets the coin edge detector act in the same cycle the level is accepted.
  assign o_next = w_hit ? r_sync[1] : r_deb;
  assign o_deb  = r_deb;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_deb  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_deb  <= o_next;
      r_cnt  <= (!w_diff || w_hit) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces both joysticks, runs the coin pulse FSM and maps controls per game.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = 24000,
  parameter int COIN_ON    = 2400000,
  parameter int COIN_OFF   = 2400000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [7:0]  mod,
  input  logic [1:0]  ctrl_mode,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic        def_state,
  input  logic [7:0]  sw0,
  input  logic [7:0]  sw1,
  input  logic [7:0]  sw2,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic [7:0]  in2,
  output logic        coin_busy
);
  localparam int CMAX = COIN_ON > COIN_OFF ? COIN_ON : COIN_OFF;
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [31:0] COIN_MASK = (32'd1 << B_COIN) | (32'd1 << (16 + B_COIN));
  logic [31:0]  w_deb;
  logic [31:0]  w_next;
  logic [15:0]  w_btn;
  logic         w_coin_rise;
  coin_state_t  r_state;
  logic [CW-1:0] r_cnt;
  for (genvar i = 0; i < 32; i++) begin : g_deb
    input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk (clk_sys),
      .i_rst (reset),
      .i_raw (i < 16 ? joy1[i % 16] : joy2[i % 16]),
      .o_deb (w_deb[i]),
      .o_next(w_next[i])
    );
  end
  assign w_btn       = w_deb[15:0] | w_deb[31:16];
  assign w_coin_rise = |(w_next & COIN_MASK) && !w_btn[B_COIN];
  assign coin_busy   = r_state != ST_IDLE;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      in0     <= '0;
      in1     <= '0;
      in2     <= '0;
    end else begin
      in0 <= sw0 | {3'b0, r_state == ST_ON, w_btn[B_HSRESET], 1'b0, w_btn[B_ADVANCE], w_btn[B_AUTOUP]};
      {in2, in1} <= map_game(mod, ctrl_mode, def_state, w_btn) | {sw2, sw1};
      // Only IDLE looks at the coin edge, so presses during ON/GAP are dropped.
      case (r_state)
        ST_IDLE: if (w_coin_rise) begin
          r_state <= ST_ON;
          r_cnt   <= '0;
        end
        ST_ON: if (r_cnt >= CW'(COIN_ON - 1)) begin
          r_state <= ST_GAP;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 1'b1;
        ST_GAP: if (r_cnt >= CW'(COIN_OFF - 1)) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: cycle model of the conditioner compared every cycle, plus directed literal checks.
module tb_input_conditioner;
  localparam int DEB = 4;
  localparam int CON = 10;
  localparam int COFF = 6;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] mod, sw0, sw1, sw2, in0, in1, in2;
  logic [1:0] ctrl_mode;
  logic [15:0] joy1, joy2;
  logic def_state, coin_busy;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  input_conditioner #(.DEB_CYCLES(DEB), .COIN_ON(CON), .COIN_OFF(COFF)) dut (
    .clk_sys(clk), .reset(reset), .mod(mod), .ctrl_mode(ctrl_mode), .joy1(joy1), .joy2(joy2),
    .def_state(def_state), .sw0(sw0), .sw1(sw1), .sw2(sw2), .in0(in0), .in1(in1), .in2(in2),
    .coin_busy(coin_busy));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [15:0] ref_game(input logic [7:0] m, input logic [1:0] cm,
                                           input logic ds, input logic [15:0] b);
    logic x, y;
    logic [7:0] a, c;
    x = b[1] | b[0];
    y = b[5];
    if (cm == 2'b10) begin
      x = b[8];
      y = b[5];
    end else if (cm == 2'b01) begin
      x = ds ? b[0] : b[1];
      y = ds ? b[1] : b[0];
    end
    a = 8'h0;
    c = 8'h0;
    if (m == 8'd0) begin a = {b[2], x, b[9], b[10], b[7], b[6], y, b[4]}; c[0] = b[3]; end
    if (m == 8'd1) begin a = {b[5], b[4], b[9], b[10], b[3], b[1], b[0], b[2]}; c[0] = b[6]; end
    if (m == 8'd2) begin a = {b[2], 1'b0, b[9], b[10], b[5], b[6], b[0], b[4]}; c[0] = b[3]; end
    if (m == 8'd3) a = {b[5], b[4], b[9], b[10], b[0], b[1], b[2], b[3]};
    return {c, a};
  endfunction
  // Model: raw bits delayed two cycles, a run length of disagreement per bit, and a coin phase clock.
  logic [31:0] m_s1, m_s2, m_deb;
  logic [15:0] m_b, m_nb, m_g;
  int m_run[32];
  int m_phase;
  logic m_valid = 1'b0;
  logic [7:0] e_in0, e_in1, e_in2;
  logic e_busy;
  always @(posedge clk) begin
    m_valid = 1'b1;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_phase = -1;
      for (int i = 0; i < 32; i++) m_run[i] = 0;
      e_in0 = 0; e_in1 = 0; e_in2 = 0; e_busy = 0;
    end else begin
      m_b = m_deb[15:0] | m_deb[31:16];
      e_in0 = sw0 | {3'b0, (m_phase >= 0 && m_phase < CON), m_b[14], 1'b0, m_b[12], m_b[13]};
      m_g = ref_game(mod, ctrl_mode, def_state, m_b);
      e_in1 = m_g[7:0] | sw1;
      e_in2 = m_g[15:8] | sw2;
      for (int i = 0; i < 32; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = {joy2, joy1};
      m_nb = m_deb[15:0] | m_deb[31:16];
      if (m_phase >= 0) begin
        m_phase++;
        if (m_phase == CON + COFF) m_phase = -1;
      end else if (m_nb[11] && !m_b[11]) m_phase = 0;
      e_busy = m_phase >= 0;
    end
  end
  always @(negedge clk) if (m_valid) begin
    chk("in0", in0, e_in0);
    chk("in1", in1, e_in1);
    chk("in2", in2, e_in2);
    chk("coin_busy", coin_busy, e_busy);
  end
  logic [7:0] g_mod[5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7};
  logic [7:0] g_in1[5] = '{8'hFF, 8'hFF, 8'hBF, 8'hFF, 8'hA5};
  logic [7:0] g_in2[5] = '{8'h31, 8'h31, 8'h31, 8'h30, 8'h30};
  int rise, on_cnt, busy_cnt, edges;
  logic seen, prev, found;
  initial begin
    reset = 1; mod = 0; ctrl_mode = 0; joy1 = 0; joy2 = 0; def_state = 0;
    sw0 = 0; sw1 = 0; sw2 = 0;
    tick(3);
    chk("rst_in0", in0, 0);
    chk("rst_in1", in1, 0);
    chk("rst_busy", coin_busy, 0);
    reset = 0;
    tick(3);
    // Glitch then sustained press on Fire A.
    joy1[4] = 1;
    tick(3);
    joy1[4] = 0;
    seen = 0;
    repeat (12) begin tick(1); if (in1[0]) seen = 1; end
    chk("glitch_blocked", seen, 0);
    joy1[4] = 1;
    rise = -1;
    for (int k = 1; k <= 20; k++) begin tick(1); if (in1[0] && rise < 0) rise = k; end
    chk("deb_latency", rise, 7);
    joy1 = 0;
    tick(10);
    // Coin pulse with an overlapping second press.
    on_cnt = 0; busy_cnt = 0; edges = 0; prev = 0;
    joy2[11] = 1;
    for (int c = 0; c < 60; c++) begin
      if (c == 12) joy1[11] = 1;
      if (c == 30) joy2[11] = 0;
      if (c == 42) joy1[11] = 0;
      tick(1);
      on_cnt += int'(in0[4]);
      busy_cnt += int'(coin_busy);
      if (in0[4] && !prev) edges++;
      prev = in0[4];
    end
    chk("coin_on_len", on_cnt, 10);
    chk("coin_busy_len", busy_cnt, 16);
    chk("coin_pulses", edges, 1);
    tick(10);
    // Mode 2 with R held, then facing flipped.
    ctrl_mode = 2'b01; def_state = 1; joy1[0] = 1;
    tick(8);
    chk("mode2_right", in1, 8'h40);
    def_state = 0;
    tick(1);
    chk("mode2_left", in1, 8'h02);
    joy1 = 0; ctrl_mode = 0;
    tick(8);
    // Game sweep with every button held.
    sw1 = 8'hA5; sw2 = 8'h30; joy1 = 16'hFFFF;
    tick(8);
    for (int g = 0; g < 5; g++) begin
      mod = g_mod[g];
      tick(1);
      chk("game_in1", in1, g_in1[g]);
      chk("game_in2", in2, g_in2[g]);
    end
    joy1 = 0; sw1 = 0; sw2 = 0; mod = 0;
    tick(40);
    // Reset in the middle of a coin pulse, coin still held.
    joy2[11] = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin tick(1); found = coin_busy; end
    chk("coin_start", found, 1);
    tick(4);
    reset = 1;
    tick(1);
    chk("rst_mid_in0", in0, 0);
    chk("rst_mid_busy", coin_busy, 0);
    reset = 0;
    rise = -1;
    for (int k = 1; k <= 15; k++) begin tick(1); if (in0[4] && rise < 0) rise = k; end
    chk("coin_after_rst", rise, 7);
    joy2 = 0;
    tick(30);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
